// File: rtl/cnn_run_state_tracker.sv
// Tracks the CNN accelerator run sequence and packs state/layer/violation into one PIO status word.
// Latency: 1 cycle from input pulse to outputs; no backpressure, every pulse is sampled on every clock.
module cnn_run_state_tracker #(
    parameter int NUM_LAYERS     = 4,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       weights_loaded,
    input  logic       layer_done,
    input  logic       ack,
    output logic [7:0] status,
    output logic       busy,
    output logic       irq
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERROR   = 3'd4
    } state_t;

    localparam logic [3:0]       LAST_LAYER = 4'(NUM_LAYERS - 1);
    localparam logic [CNT_W-1:0] WD_LIMIT   = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       layer_q, layer_d;
    logic             viol_q, viol_d;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic             busy_d, irq_d;
    logic             expired;

    assign expired = (wd_q == WD_LIMIT);

    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        viol_d  = viol_q;
        // Watchdog defaults to zero: covers every phase entry and the idle/terminal states.
        wd_d    = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    layer_d = '0;
                end
            end
            ST_LOAD: begin
                if (start || layer_done) viol_d = 1'b1;
                if (weights_loaded)  state_d = ST_COMPUTE;
                else if (expired)    state_d = ST_ERROR;
                else                 wd_d    = wd_q + CNT_W'(1);
            end
            ST_COMPUTE: begin
                if (start || weights_loaded) viol_d = 1'b1;
                if (layer_done) begin
                    if (layer_q == LAST_LAYER) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_LOAD;
                        layer_d = layer_q + 4'd1;
                    end
                end else if (expired) begin
                    state_d = ST_ERROR;
                end else begin
                    wd_d = wd_q + CNT_W'(1);
                end
            end
            ST_DONE, ST_ERROR: begin
                // ack outranks a simultaneous start, which is then dropped silently.
                if (ack) begin
                    state_d = ST_IDLE;
                    layer_d = '0;
                    viol_d  = 1'b0;
                end else if (start) begin
                    viol_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                layer_d = '0;
            end
        endcase

        busy_d = (state_d == ST_LOAD) || (state_d == ST_COMPUTE);
        irq_d  = (state_d == ST_DONE) || (state_d == ST_ERROR);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            layer_q <= '0;
            viol_q  <= 1'b0;
            wd_q    <= '0;
            busy    <= 1'b0;
            irq     <= 1'b0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            viol_q  <= viol_d;
            wd_q    <= wd_d;
            busy    <= busy_d;
            irq     <= irq_d;
        end
    end

    assign status = {viol_q, layer_q, state_q};

endmodule

// File: tb/tb_cnn_run_state_tracker.sv
// Directed and randomized checks of the run-state tracker against an elapsed-time reference model.
module tb_cnn_run_state_tracker;

    localparam int N = 3;
    localparam int T = 8;
    localparam int W = 3;

    localparam int M_IDLE = 0, M_LOAD = 1, M_COMP = 2, M_DONE = 3, M_ERR = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start, weights_loaded, layer_done, ack;
    logic [7:0] status;
    logic       busy, irq;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int m_state, m_layer, m_viol, m_entry;

    always #5 clk = ~clk;

    cnn_run_state_tracker #(
        .NUM_LAYERS    (N),
        .TIMEOUT_CYCLES(T),
        .CNT_W         (W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .weights_loaded(weights_loaded),
        .layer_done    (layer_done),
        .ack           (ack),
        .status        (status),
        .busy          (busy),
        .irq           (irq)
    );

    task automatic model_reset();
        m_state = M_IDLE;
        m_layer = 0;
        m_viol  = 0;
        m_entry = cyc;
    endtask

    task automatic enter_phase(input int st);
        m_state = st;
        m_entry = cyc;
    endtask

    // A phase times out once it has lasted T clock edges without progress.
    task automatic model_edge(input bit s, input bit w, input bit l, input bit a);
        cyc++;
        case (m_state)
            M_IDLE: begin
                if (s) begin
                    m_layer = 0;
                    enter_phase(M_LOAD);
                end
            end
            M_LOAD: begin
                if (s || l) m_viol = 1;
                if (w) enter_phase(M_COMP);
                else if (cyc - m_entry == T) m_state = M_ERR;
            end
            M_COMP: begin
                if (s || w) m_viol = 1;
                if (l) begin
                    if (m_layer == N - 1) begin
                        m_state = M_DONE;
                    end else begin
                        m_layer = m_layer + 1;
                        enter_phase(M_LOAD);
                    end
                end else if (cyc - m_entry == T) begin
                    m_state = M_ERR;
                end
            end
            default: begin
                if (a) begin
                    m_state = M_IDLE;
                    m_layer = 0;
                    m_viol  = 0;
                end else if (s) begin
                    m_viol = 1;
                end
            end
        endcase
    endtask

    task automatic check(input string tag);
        logic [7:0] es;
        logic       eb, ei;
        es = 8'(m_viol * 128 + m_layer * 8 + m_state);
        eb = (m_state == M_LOAD) || (m_state == M_COMP);
        ei = (m_state == M_DONE) || (m_state == M_ERR);
        vectors++;
        assert (status === es) else begin
            miscompares++;
            $error("FAIL %s status: got %h expected %h", tag, status, es);
        end
        vectors++;
        assert (busy === eb) else begin
            miscompares++;
            $error("FAIL %s busy: got %b expected %b", tag, busy, eb);
        end
        vectors++;
        assert (irq === ei) else begin
            miscompares++;
            $error("FAIL %s irq: got %b expected %b", tag, irq, ei);
        end
    endtask

    task automatic check_lit(input string tag, input logic [7:0] exp);
        vectors++;
        assert (status === exp) else begin
            miscompares++;
            $error("FAIL %s status: got %h expected %h", tag, status, exp);
        end
    endtask

    task automatic tick(input bit s, input bit w, input bit l, input bit a, input string tag);
        start          = s;
        weights_loaded = w;
        layer_done     = l;
        ack            = a;
        @(posedge clk);
        model_edge(s, w, l, a);
        #1;
        start          = 1'b0;
        weights_loaded = 1'b0;
        layer_done     = 1'b0;
        ack            = 1'b0;
        check(tag);
    endtask

    initial begin
        reset_n        = 1'b0;
        start          = 1'b0;
        weights_loaded = 1'b0;
        layer_done     = 1'b0;
        ack            = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset");
        check_lit("reset_lit", 8'h00);
        reset_n = 1'b1;

        // Inputs other than start are ignored in IDLE.
        tick(0, 0, 0, 1, "idle_ack");
        tick(0, 1, 0, 0, "idle_wl");
        tick(0, 0, 1, 0, "idle_ld");
        check_lit("idle_lit", 8'h00);

        // Normal three-layer run.
        tick(1, 0, 0, 0, "run_start");   check_lit("run_start_lit", 8'h01);
        tick(0, 1, 0, 0, "run_wl0");     check_lit("run_wl0_lit", 8'h02);
        tick(0, 0, 1, 0, "run_ld0");     check_lit("run_ld0_lit", 8'h09);
        tick(0, 1, 0, 0, "run_wl1");     check_lit("run_wl1_lit", 8'h0A);
        tick(0, 0, 1, 0, "run_ld1");     check_lit("run_ld1_lit", 8'h11);
        tick(0, 1, 0, 0, "run_wl2");     check_lit("run_wl2_lit", 8'h12);
        tick(0, 0, 1, 0, "run_done");    check_lit("run_done_lit", 8'h13);
        tick(0, 0, 0, 1, "run_ack");     check_lit("run_ack_lit", 8'h00);

        // Watchdog expiry in LOAD after T cycles without progress.
        tick(1, 0, 0, 0, "wd_start");
        for (int i = 1; i < T; i++) begin
            tick(0, 0, 0, 0, "wd_wait");
            check_lit("wd_wait_lit", 8'h01);
        end
        tick(0, 0, 0, 0, "wd_expire");   check_lit("wd_expire_lit", 8'h04);
        tick(0, 0, 0, 0, "err_hold");
        tick(1, 0, 0, 1, "err_ack_start"); check_lit("err_ack_start_lit", 8'h00);
        tick(0, 0, 0, 0, "err_no_restart"); check_lit("err_no_restart_lit", 8'h00);

        // Progress on the expiry cycle wins, in both LOAD and COMPUTE.
        tick(1, 0, 0, 0, "ew_start");
        for (int i = 1; i < T; i++) tick(0, 0, 0, 0, "ew_load_wait");
        tick(0, 1, 0, 0, "ew_load_win"); check_lit("ew_load_win_lit", 8'h02);
        for (int i = 1; i < T; i++) tick(0, 0, 0, 0, "ew_comp_wait");
        tick(0, 0, 1, 0, "ew_comp_win"); check_lit("ew_comp_win_lit", 8'h09);
        tick(1, 0, 0, 0, "ew_viol");     check_lit("ew_viol_lit", 8'h89);
        for (int i = 1; i < T; i++) tick(0, 0, 0, 0, "ew_err_wait");
        tick(0, 0, 0, 0, "ew_err");      check_lit("ew_err_lit", 8'h8C);
        tick(0, 0, 0, 1, "ew_ack");

        // Protocol violation is sticky through the run and cleared by ack.
        tick(1, 0, 0, 0, "pv_start");
        tick(0, 0, 1, 0, "pv_ld_in_load"); check_lit("pv_ld_in_load_lit", 8'h81);
        tick(0, 1, 0, 0, "pv_wl0");
        tick(0, 0, 1, 0, "pv_ld0");
        tick(0, 1, 0, 0, "pv_wl1");
        tick(0, 0, 1, 0, "pv_ld1");
        tick(0, 1, 0, 0, "pv_wl2");
        tick(0, 0, 1, 0, "pv_done");     check_lit("pv_done_lit", 8'h93);
        tick(1, 0, 0, 0, "pv_start_done"); check_lit("pv_start_done_lit", 8'h93);
        tick(0, 0, 0, 1, "pv_ack");      check_lit("pv_ack_lit", 8'h00);

        // Simultaneous weights_loaded+layer_done in LOAD, then stray pulses in COMPUTE.
        tick(1, 0, 0, 0, "sim_start");
        tick(0, 1, 1, 0, "sim_wl_ld");   check_lit("sim_wl_ld_lit", 8'h82);
        tick(0, 1, 0, 0, "sim_wl_comp"); check_lit("sim_wl_comp_lit", 8'h82);
        tick(0, 0, 0, 1, "sim_ack_comp"); check_lit("sim_ack_comp_lit", 8'h82);
        tick(0, 0, 1, 0, "sim_ld0");
        tick(0, 1, 0, 0, "sim_wl1");
        tick(0, 0, 1, 0, "sim_ld1");
        tick(0, 1, 0, 0, "sim_wl2");     check_lit("sim_wl2_lit", 8'h92);

        // Asynchronous reset in COMPUTE, layer 2: outputs clear before any clock edge.
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("async_reset");
        check_lit("async_reset_lit", 8'h00);
        #2;
        reset_n = 1'b1;
        tick(1, 0, 0, 0, "post_reset_start"); check_lit("post_reset_start_lit", 8'h01);
        tick(0, 1, 0, 0, "post_reset_wl");    check_lit("post_reset_wl_lit", 8'h02);

        // Randomized pulse traffic against the model.
        for (int i = 0; i < 800; i++) begin
            tick(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
